glove_window_sequencer: RTL
===========================

# glove_window_sequencer

Front-end controller for `Core`: it accepts the glove's per-channel sensor stream and assembles 8-channel frames into the 5-frame sliding window that `Core` consumes as `i_data`. It issues one `i_next` kick per new frame once the window is full, then holds the window stable until `Core` answers with a letter, a finished word, or a timeout. It also logs emitted letters and latches the final word.

## Interface
- `CHANNELS`, 8, samples per frame
- `FRAMES`, 5, frames held in the window (window = CHANNELS*FRAMES words)
- `WIDTH`, 16, sample width (signed Q7.8, passed through untouched)
- `TIMEOUT`, 500, WAIT cycles before giving up on a frame

- `i_clk` in 1 — single clock, rising edge
- `i_rst_n` in 1 — synchronous reset, active-high (asserted = 1), sampled on `i_clk`
- `i_sample_valid` in 1 — sample offered
- `i_sample` in WIDTH — sample; channel order 0..CHANNELS-1 implied by arrival order
- `o_sample_ready` out 1 — sample accepted when valid && ready
- `o_data` out WIDTH x (CHANNELS*FRAMES) — window to Core `i_data`; index f*CHANNELS+c, frame 0 oldest
- `o_core_next` out 1 — to Core `i_next`; single-cycle pulse
- `i_core_next` in 1 — Core `o_next`, letter ready
- `i_core_finished` in 1 — Core `o_finished`
- `i_core_letter` in 8 — Core `o_letter`
- `i_core_word` in 120 — Core `o_word`
- `i_core_length` in 4 — Core `o_length`
- `o_letter_valid` out 1 — one-cycle strobe, letter logged
- `o_letter` out 8 — last logged letter (held)
- `o_done` out 1 — sticky word-complete flag
- `o_word` out 120, `o_length` out 4 — latched final word
- `o_timeouts` out 8 — count of timed-out frames, saturates at 255

## Operation
- States: `COLLECT`, `KICK`, `WAIT`, `DONE`. Reset enters `COLLECT`.
- `COLLECT`: `o_sample_ready`=1. Each accepted sample is written to staging slot `ch`, and `ch` increments.
  - On acceptance with `ch`==CHANNELS-1, the window shifts in the same edge:
    - frame f ← frame f+1 for f < FRAMES-1;
    - the last frame ← staging slots 0..CHANNELS-2 plus the current sample;
    - `ch` ← 0; `fill` increments, saturating at FRAMES.
  - If the post-shift `fill`==FRAMES, go to `KICK`; otherwise stay in `COLLECT`. No kicks occur during warm-up (first FRAMES-1 frames).
- `KICK`: `o_core_next`=1 for exactly this cycle, ready=0. Next state `WAIT`; the timeout counter clears to 0.
- `WAIT`: ready=0. The window is frozen. Priority order:
  1. `i_core_finished`: latch `i_core_word`/`i_core_length`, set `o_done`, go to `DONE`. A simultaneous `i_core_next` is ignored; no letter is logged.
  2. `i_core_next`: `o_letter` ← `i_core_letter`, pulse `o_letter_valid`, go to `COLLECT`.
  3. Counter == TIMEOUT-1: increment `o_timeouts` (saturating), go to `COLLECT`.
  4. Otherwise: counter increments.
- `DONE`: ready=0, no kicks. All outputs hold until reset.
- Core inputs are ignored outside `WAIT`.
- A partial frame is never shifted in. Samples offered while ready=0 are not consumed, and the producer must hold them.

## Timing
- Reset values: `o_data` all 0; `o_sample_ready`=1 (COLLECT); `o_core_next`=0; `o_letter_valid`=0; `o_letter`=0; `o_done`=0; `o_word`=0; `o_length`=0; `o_timeouts`=0. Internally `ch`=0 and `fill`=0.
- All outputs are registered.
- Last sample of a frame accepted at edge N:
  - `o_data` updates at N;
  - `o_core_next` is high from N to N+1;
  - state is `WAIT` from N+1.
- Core response sampled at edge M in `WAIT`:
  - `o_letter_valid` is high from M to M+1;
  - `o_sample_ready` rises at M.
- Timeout: with no response, exactly TIMEOUT cycles are spent in `WAIT`, then `COLLECT` is entered.
- Reset asserted in any state, including mid-frame or in `WAIT`: at the next edge everything returns to reset values and the partial frame is discarded. Reset dominates all other inputs.
- `fill` stays saturated after warm-up, so every later complete frame produces exactly one kick.

## Test plan
- Warm-up: stream 5 frames (values f*16+c) with valid held high.
  - No `o_core_next` during frames 0–3.
  - A single one-cycle pulse after the 40th sample.
  - `o_data[0]`=0, `o_data[39]`=71.
  - Ready is low from the pulse cycle onward.
- Letter: in `WAIT`, drive `i_core_next`=1 with letter 8'h03 after 20 cycles.
  - `o_letter_valid` pulses once with `o_letter`=3.
  - Ready returns; the next 8 samples shift the window by one frame and trigger a second kick.
- Timeout: never respond.
  - After exactly 500 `WAIT` cycles, `o_timeouts`=1 and ready=1.
  - The window is unchanged until the next full frame.
- Finished with simultaneous letter: assert `i_core_finished` and `i_core_next` together, with length 4 and word 120'h04030201.
  - `o_done`=1, `o_length`=4, `o_word` latched.
  - No `o_letter_valid`.
  - Ready stays low and no further kicks occur despite valid input.
- Backpressure: toggle valid randomly for 12 frames and hold each sample while ready is low.
  - Window contents match a reference shift model.
  - Exactly 8 kicks occur.
- Reset mid-frame: after 3 samples of frame 2, assert `i_rst_n`=1 for one cycle.
  - All outputs return to reset values.
  - A fresh 5-frame warm-up is required before the first kick.

Source files
------------

// File: rtl/glove_window_sequencer.sv
// glove_window_sequencer
//   Front end for Core. It collects per-channel glove samples into frames and
//   keeps the last FRAMES frames as a sliding window. Once the window is full,
//   it kicks Core once per new frame and freezes the window until Core returns
//   a letter, a finished word, or the wait times out.
// Ports
//   i_clk, i_rst_n      clock; synchronous reset, active HIGH despite the name
//   i_sample_valid/i_sample, o_sample_ready   sample stream (valid/ready)
//   o_data              window, word f*CHANNELS+c, frame 0 is the oldest
//   o_core_next         one-cycle kick to Core
//   i_core_*            Core response (next/finished/letter/word/length)
//   o_letter_valid/o_letter   letter log strobe and last letter
//   o_done/o_word/o_length    sticky word-complete flag and latched word
//   o_timeouts          count of timed-out frames, saturating
module glove_window_sequencer #(
    parameter int CHANNELS = 8,
    parameter int FRAMES   = 5,
    parameter int WIDTH    = 16,
    parameter int TIMEOUT  = 500
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_sample_valid,
    input  logic [WIDTH-1:0]                       i_sample,
    output logic                                   o_sample_ready,
    output logic [CHANNELS*FRAMES-1:0][WIDTH-1:0]  o_data,
    output logic                                   o_core_next,
    input  logic                                   i_core_next,
    input  logic                                   i_core_finished,
    input  logic [7:0]                             i_core_letter,
    input  logic [119:0]                           i_core_word,
    input  logic [3:0]                             i_core_length,
    output logic                                   o_letter_valid,
    output logic [7:0]                             o_letter,
    output logic                                   o_done,
    output logic [119:0]                           o_word,
    output logic [3:0]                             o_length,
    output logic [7:0]                             o_timeouts
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = $clog2(FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(FRAMES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_KICK    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]                       state;
    logic [CW-1:0]                    ch;
    logic [FW-1:0]                    fill;
    logic [TW-1:0]                    wcnt;
    logic [CHANNELS-2:0][WIDTH-1:0]   stage;

    logic [FW-1:0] fill_nxt;
    logic          frame_end;

    assign fill_nxt  = (fill == FILL_MAX) ? fill : fill + 1'b1;
    // The last channel is never staged. It goes straight into the window with
    // the staged slots, so a frame lands in the same edge it completes.
    assign frame_end = (state == S_COLLECT) && i_sample_valid && (ch == CH_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state          <= S_COLLECT;
            ch             <= '0;
            fill           <= '0;
            wcnt           <= '0;
            stage          <= '0;
            o_data         <= '0;
            o_sample_ready <= 1'b1;
            o_core_next    <= 1'b0;
            o_letter_valid <= 1'b0;
            o_letter       <= '0;
            o_done         <= 1'b0;
            o_word         <= '0;
            o_length       <= '0;
            o_timeouts     <= '0;
        end else begin
            o_core_next    <= 1'b0;
            o_letter_valid <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (frame_end) begin
                        for (int f = 0; f < FRAMES - 1; f++)
                            o_data[f*CHANNELS +: CHANNELS] <= o_data[(f+1)*CHANNELS +: CHANNELS];
                        o_data[(FRAMES-1)*CHANNELS +: CHANNELS] <= {i_sample, stage};
                        ch   <= '0;
                        fill <= fill_nxt;
                        // During warm-up the window is only partly valid, so no kick.
                        if (fill_nxt == FILL_MAX) begin
                            state          <= S_KICK;
                            o_core_next    <= 1'b1;
                            o_sample_ready <= 1'b0;
                        end
                    end else if (i_sample_valid) begin
                        stage[ch] <= i_sample;
                        ch        <= ch + 1'b1;
                    end
                end
                S_KICK: begin
                    state <= S_WAIT;
                    wcnt  <= '0;
                end
                S_WAIT: begin
                    // A finished word wins over a letter in the same cycle.
                    if (i_core_finished) begin
                        o_word   <= i_core_word;
                        o_length <= i_core_length;
                        o_done   <= 1'b1;
                        state    <= S_DONE;
                    end else if (i_core_next) begin
                        o_letter       <= i_core_letter;
                        o_letter_valid <= 1'b1;
                        o_sample_ready <= 1'b1;
                        state          <= S_COLLECT;
                    end else if (wcnt == TO_LAST) begin
                        if (o_timeouts != 8'hFF)
                            o_timeouts <= o_timeouts + 8'd1;
                        o_sample_ready <= 1'b1;
                        state          <= S_COLLECT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: ; // S_DONE holds everything until reset
            endcase
        end
    end

endmodule
